// File: rtl/muldiv_pkg.sv
// muldiv_pkg: FSM states, RV32M funct3 codes, ALU opcodes and funct3 decode helpers shared by muldiv_seq
package muldiv_pkg;
  typedef enum logic [2:0] {S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FIX_LO, S_FIX_HI, S_DONE} state_e;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SUB = 4'd9;
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction
  function automatic logic is_rem(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction
  function automatic logic is_mulh(input logic [2:0] f3);
    return ~f3[2] & (f3[1:0] != 2'b00);
  endfunction
endpackage

// File: rtl/muldiv_special_detect.sv
// muldiv_special_detect: operand sign handling and RISC-V corner-case flags (divide by zero, signed overflow, zero operand)
module muldiv_special_detect import muldiv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            div0,
  output logic            ovf,
  output logic            zero_opnd,
  output logic            neg_a,
  output logic            neg_b,
  output logic            neg_res
);
  logic sgn_a, sgn_b;
  always_comb begin
    sgn_a = funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    sgn_b = funct3 inside {F3_MULH, F3_DIV, F3_REM};
    neg_a = sgn_a & rs1[XLEN-1];
    neg_b = sgn_b & rs2[XLEN-1];
    div0 = is_div(funct3) & (rs2 == '0);
    ovf = (funct3 inside {F3_DIV, F3_REM}) & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2);
    zero_opnd = (rs1 == '0) | (rs2 == '0);
    neg_res = (funct3 inside {F3_MULHSU, F3_REM}) ? neg_a :
              (funct3 inside {F3_MUL, F3_MULH, F3_DIV}) ? neg_a ^ neg_b : 1'b0;
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer driving the shared EX-stage ALU one op per cycle.
// Define MULDIV_EARLY_OUT_EN to finish special-case and zero-operand ops straight from IDLE.
module muldiv_seq import muldiv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            alu_sel,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_c
);
  localparam int ITERS = XLEN;
  localparam int CW = $clog2(ITERS);
  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_EARLY_OUT_EN
  localparam logic EARLY = 1'b1;
`else
  localparam logic EARLY = 1'b0;
`endif
  state_e state, state_d;
  logic [2:0] f3_q, sel_f3;
  logic [XLEN-1:0] a_q, b_q, sel_a, sel_b, mag_a, mag_b, hi, lo;
  logic [XLEN-1:0] div_s, w_lo, fsm_res, spec_res;
  logic [CW-1:0] cnt;
  logic idle, go, early, carry, take, hfix;
  logic div0, ovf, zero_opnd, neg_a, neg_b, neg_res;
  // in IDLE the flags describe the incoming op (early-out), afterwards the latched one
  always_comb begin
    idle = state == S_IDLE;
    sel_f3 = idle ? funct3 : f3_q;
    sel_a = idle ? rs1 : a_q;
    sel_b = idle ? rs2 : b_q;
  end
  muldiv_special_detect #(.XLEN(XLEN)) u_det (
    .funct3(sel_f3), .rs1(sel_a), .rs2(sel_b),
    .div0(div0), .ovf(ovf), .zero_opnd(zero_opnd),
    .neg_a(neg_a), .neg_b(neg_b), .neg_res(neg_res)
  );
  always_comb begin
    go = start & ~kill;
    early = EARLY & (div0 | ovf | zero_opnd);
    state_d = state;
    case (state)
      S_IDLE:   state_d = go ? (early ? S_DONE : S_NEG_A) : S_IDLE;
      S_NEG_A:  state_d = S_NEG_B;
      S_NEG_B:  state_d = S_ITER;
      S_ITER:   state_d = (cnt == CW'(ITERS-1)) ? S_FIX_LO : S_ITER;
      S_FIX_LO: state_d = S_FIX_HI;
      S_FIX_HI: state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end
  always_comb begin
    busy = ~idle;
    done = state == S_DONE;
    alu_sel = state inside {S_NEG_A, S_NEG_B, S_ITER, S_FIX_LO, S_FIX_HI};
    div_s = {hi[XLEN-2:0], lo[XLEN-1]};
    w_lo = is_rem(f3_q) ? hi : lo;
    hfix = is_mulh(f3_q);
    alu_a = '0;
    alu_b = '0;
    alu_op = ALU_ADD;
    case (state)
      S_NEG_A: begin
        alu_a = neg_a ? '0 : a_q;
        alu_b = neg_a ? a_q : '0;
        alu_op = neg_a ? ALU_SUB : ALU_ADD;
      end
      S_NEG_B: begin
        alu_a = neg_b ? '0 : b_q;
        alu_b = neg_b ? b_q : '0;
        alu_op = neg_b ? ALU_SUB : ALU_ADD;
      end
      S_ITER: begin
        alu_a = is_div(f3_q) ? div_s : hi;
        alu_b = is_div(f3_q) ? mag_b : (lo[0] ? mag_a : '0);
        alu_op = is_div(f3_q) ? ALU_SUB : ALU_ADD;
      end
      S_FIX_LO: begin
        alu_a = neg_res ? '0 : w_lo;
        alu_b = neg_res ? w_lo : '0;
        alu_op = neg_res ? ALU_SUB : ALU_ADD;
      end
      S_FIX_HI: begin
        alu_a = (hfix & ~(neg_res & (lo == '0))) ? hi : '0;
        alu_b = (hfix & neg_res) ? ((lo == '0) ? hi : ONES) : '0;
        alu_op = (hfix & neg_res) ? ((lo == '0) ? ALU_SUB : ALU_XOR) : ALU_ADD;
      end
      default: ;
    endcase
    carry = alu_c < alu_a;
    take = hi[XLEN-1] | ~(div_s < mag_b);
    fsm_res = hfix ? alu_c : w_lo;
    spec_res = div0 ? (is_rem(sel_f3) ? sel_a : ONES) : ovf ? (is_rem(sel_f3) ? '0 : MINV) : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q <= '0;
      a_q <= '0;
      b_q <= '0;
      mag_a <= '0;
      mag_b <= '0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      result <= '0;
    end else begin
      cnt <= (state == S_ITER) ? cnt + 1'b1 : '0;
      if (idle & go) begin
        f3_q <= funct3;
        a_q <= rs1;
        b_q <= rs2;
      end
      if (idle & go & early) result <= spec_res;
      if (state == S_NEG_A) mag_a <= alu_c;
      if (state == S_NEG_B) begin
        mag_b <= alu_c;
        lo <= is_div(f3_q) ? mag_a : alu_c;
        hi <= '0;
      end
      // multiply shifts {carry,sum,mplier} right; divide shifts the quotient bit in from the right
      if (state == S_ITER) begin
        hi <= is_div(f3_q) ? (take ? alu_c : div_s) : {carry, alu_c[XLEN-1:1]};
        lo <= is_div(f3_q) ? {lo[XLEN-2:0], take} : {alu_c[0], lo[XLEN-1:1]};
      end
      if (state == S_FIX_LO) begin
        if (is_rem(f3_q)) hi <= alu_c;
        else lo <= alu_c;
      end
      if ((state == S_FIX_HI) & ~kill) result <= (div0 | ovf) ? spec_res : fsm_res;
    end
  end
endmodule
